// File: rtl/fetch_buffer.sv
// Instruction-fetch front end for a one-cycle-latency BRAM: sequential prefetch into a
// small queue, with bypass of the arriving word, decode stalls and execute redirects.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid_f,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fpc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;

    logic          resp;
    logic          queued;
    logic          bypass;
    logic          pop;
    logic          q_write;
    logic          q_read;
    logic [CW:0]   occupancy;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        resp      = inflight & ~kill;
        queued    = (count != '0);
        bypass    = ~queued & resp;
        valid_f   = ~reset & (queued | resp);
        head_pc    = queued ? q_pc[rd_ptr]    : req_pc;
        head_instr = queued ? q_instr[rd_ptr] : imem_rdata;

        pop       = valid_f & ~stall & ~redirect;
        q_write   = resp & ~redirect & ~(bypass & pop);
        q_read    = pop & queued;

        // Issue only if the answer is guaranteed a slot once this cycle's pop is taken.
        occupancy = {1'b0, count} + (CW+1)'(inflight);
        imem_en   = ~reset & ~redirect & (occupancy < (CW+1)'(DEPTH) + (CW+1)'(pop));
        imem_addr = fpc;

        instr_f   = valid_f ? head_instr : NOP;
        pc_f      = valid_f ? head_pc    : 32'h0;
        pcplus4_f = pc_f + 32'd4;
    end

    // NOTE: queue storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (q_write) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            // Flush everything; the response already due is dropped by kill.
            fpc      <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            kill     <= inflight;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            kill     <= 1'b0;
            inflight <= imem_en;
            if (imem_en) begin
                req_pc <= fpc;
                fpc    <= fpc + 32'd4;
            end
            if (q_write) wr_ptr <= wr_ptr + PW'(1);
            if (q_read)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(q_write) - CW'(q_read);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queue-level reference model checked every cycle,
// plus literal expectations at the reset, stall, redirect and wrap points.
module tb_fetch_buffer;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .valid_f     (valid_f),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pcplus4_f   (pcplus4_f)
    );

    // Instruction memory contents: word i holds 0x1000_0000 + i.
    function automatic logic [31:0] word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: fetched-but-unconsumed instructions as a queue, plus the one request in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_req_pc = 32'h0;
    bit          m_inflight = 1'b0;
    bit          m_kill = 1'b0;

    always @(negedge clk) begin : model
        bit          m_resp;
        bit          m_valid;
        bit          m_pop;
        bit          m_en;
        bit          from_bypass;
        int          occ;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        entry_t      e;

        if (reset) begin
            check("m_rst_valid", 32'(valid_f), 32'h0);
            check("m_rst_en", 32'(imem_en), 32'h0);
            check("m_rst_instr", instr_f, NOP);
            check("m_rst_pc", pc_f, 32'h0);
            check("m_rst_pcplus4", pcplus4_f, 32'h4);
            mq.delete();
            m_fpc = 32'h0;
            m_inflight = 1'b0;
            m_kill = 1'b0;
        end else begin
            m_resp = m_inflight && !m_kill;
            from_bypass = 1'b0;
            if (mq.size() > 0) begin
                m_valid = 1'b1;
                e_pc = mq[0].pc;
                e_instr = mq[0].instr;
            end else if (m_resp) begin
                m_valid = 1'b1;
                from_bypass = 1'b1;
                e_pc = m_req_pc;
                e_instr = word(m_req_pc);
            end else begin
                m_valid = 1'b0;
                e_pc = 32'h0;
                e_instr = NOP;
            end
            m_pop = m_valid && !stall && !redirect;
            occ = mq.size() + (m_inflight ? 1 : 0) - (m_pop ? 1 : 0);
            m_en = !redirect && (occ < DEPTH);

            check("m_valid", 32'(valid_f), 32'(m_valid));
            check("m_instr", instr_f, e_instr);
            check("m_pc", pc_f, e_pc);
            check("m_pcplus4", pcplus4_f, e_pc + 32'd4);
            check("m_en", 32'(imem_en), 32'(m_en));
            if (m_en) check("m_addr", imem_addr, m_fpc);

            if (redirect) begin
                mq.delete();
                m_kill = m_inflight;
                m_inflight = 1'b0;
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pop && !from_bypass) void'(mq.pop_front());
                if (m_resp && !(from_bypass && m_pop)) begin
                    e.pc = m_req_pc;
                    e.instr = word(m_req_pc);
                    mq.push_back(e);
                end
                m_kill = 1'b0;
                if (m_en) begin
                    m_req_pc = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
                m_inflight = m_en;
            end
        end
    end

    // One clock cycle of stimulus; returns at that cycle's negedge for literal checks.
    task automatic cyc(input bit r, input bit s, input bit d, input logic [31:0] target);
        @(posedge clk);
        #1;
        reset = r;
        stall = s;
        redirect = d;
        redirect_pc = target;
        @(negedge clk);
    endtask

    initial begin
        // Reset and stream
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("R_en", 32'(imem_en), 32'h1);
        check("R_addr", imem_addr, 32'h0);
        check("R_valid", 32'(valid_f), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("R1_pc", pc_f, 32'h0);
        check("R1_instr", instr_f, 32'h1000_0000);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            check("stream_pc", pc_f, 32'(4 * k));
            check("stream_valid", 32'(valid_f), 32'h1);
        end

        // Stall five cycles at pc_f = 0x8
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall_pc", pc_f, 32'h8);
            check("stall_instr", instr_f, 32'h1000_0002);
            if (i >= 1) check("stall_en_drop", 32'(imem_en), 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("release_pc0", pc_f, 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("release_pc1", pc_f, 32'hC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("release_pc2", pc_f, 32'h10);
        check("release_valid", 32'(valid_f), 32'h1);

        // Fill the queue, then redirect to 0x40
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("full_pc", pc_f, 32'h14);
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_n1_valid", 32'(valid_f), 32'h0);
        check("redir_n1_instr", instr_f, NOP);
        check("redir_n1_addr", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_n2_pc", pc_f, 32'h40);
        check("redir_n2_instr", instr_f, 32'h1000_0010);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_n3_pc", pc_f, 32'h44);

        // Redirect and stall together
        cyc(1'b0, 1'b1, 1'b1, 32'h80);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("rs_n1_valid", 32'(valid_f), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("rs_n2_pc", pc_f, 32'h80);
        check("rs_n2_instr", instr_f, 32'h1000_0020);

        // Address wrap
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc_f, 32'hFFFF_FFFC);
        check("wrap_pcplus4", pcplus4_f, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_next_pc", pc_f, 32'h0);
        check("wrap_next_instr", instr_f, 32'h1000_0000);

        // Unaligned redirect target
        cyc(1'b0, 1'b0, 1'b1, 32'h42);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("unal_en", 32'(imem_en), 32'h1);
        check("unal_addr", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("unal_pc", pc_f, 32'h40);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset mid-stream with a queued entry and a response in flight
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("mrst_valid", 32'(valid_f), 32'h0);
        check("mrst_en", 32'(imem_en), 32'h0);
        check("mrst_instr", instr_f, NOP);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("mrst_R_en", 32'(imem_en), 32'h1);
        check("mrst_R_addr", imem_addr, 32'h0);
        check("mrst_R_valid", 32'(valid_f), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("mrst_R1_pc", pc_f, 32'h0);
        check("mrst_R1_instr", instr_f, 32'h1000_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("mrst_R2_pc", pc_f, 32'h4);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
